// File: rtl/pipelined_ripple_adder.sv
// Pipelined ripple-carry adder/subtractor: each stage ripples one WIDTH/STAGES chunk.
// Latency STAGES cycles, one op per cycle; stages advance independently so bubbles collapse under stall.
module pipelined_ripple_adder #(
    parameter int WIDTH  = 16,
    parameter int STAGES = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a0,
    input  logic [WIDTH-1:0] a1,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);
    localparam int CHUNK = WIDTH / STAGES;

    logic [STAGES-1:0]             vld_q, vld_d, load;
    logic [STAGES-1:0][WIDTH-1:0]  a_q, a_d, b_q, b_d, s_q, s_d;
    logic [STAGES-1:0]             c_q, c_d;
    logic                          ovf_q, ovf_d;
    logic                          accept;

    logic                          src_vld, src_c;
    logic [WIDTH-1:0]              src_a, src_b, src_s;
    logic [CHUNK:0]                chunk_sum;

    // A stage may load when it, or any stage downstream of it, has room.
    always_comb begin : p_load
        logic full_run;
        full_run = 1'b1;
        load     = '0;
        for (int k = STAGES - 1; k >= 0; k--) begin
            full_run = full_run & vld_q[k];
            load[k]  = out_ready | ~full_run;
        end
    end

    assign in_ready = load[0] & ~rst;
    assign accept   = in_valid & in_ready;

    always_comb begin
        vld_d     = vld_q;
        a_d       = a_q;
        b_d       = b_q;
        s_d       = s_q;
        c_d       = c_q;
        ovf_d     = ovf_q;
        src_vld   = 1'b0;
        src_a     = '0;
        src_b     = '0;
        src_s     = '0;
        src_c     = 1'b0;
        chunk_sum = '0;
        for (int k = 0; k < STAGES; k++) begin
            if (k == 0) begin
                src_vld = accept;
                src_a   = a0;
                src_b   = sub ? ~a1 : a1;
                src_c   = sub | cin;
                src_s   = '0;
            end else begin
                src_vld = vld_q[(k == 0) ? 0 : k - 1];
                src_a   = a_q[(k == 0) ? 0 : k - 1];
                src_b   = b_q[(k == 0) ? 0 : k - 1];
                src_c   = c_q[(k == 0) ? 0 : k - 1];
                src_s   = s_q[(k == 0) ? 0 : k - 1];
            end
            chunk_sum = {1'b0, src_a[k*CHUNK +: CHUNK]} + {1'b0, src_b[k*CHUNK +: CHUNK]}
                      + {{CHUNK{1'b0}}, src_c};
            if (load[k]) begin
                vld_d[k] = src_vld;
                if (src_vld) begin
                    a_d[k]                 = src_a;
                    b_d[k]                 = src_b;
                    s_d[k]                 = src_s;
                    s_d[k][k*CHUNK +: CHUNK] = chunk_sum[CHUNK-1:0];
                    c_d[k]                 = chunk_sum[CHUNK];
                    // Carry into the MSB is recovered as a^b^s at that bit.
                    if (k == STAGES - 1)
                        ovf_d = src_a[WIDTH-1] ^ src_b[WIDTH-1]
                              ^ chunk_sum[CHUNK-1] ^ chunk_sum[CHUNK];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_q <= '0;
            a_q   <= '0;
            b_q   <= '0;
            s_q   <= '0;
            c_q   <= '0;
            ovf_q <= 1'b0;
        end else begin
            vld_q <= vld_d;
            a_q   <= a_d;
            b_q   <= b_d;
            s_q   <= s_d;
            c_q   <= c_d;
            ovf_q <= ovf_d;
        end
    end

    // The final stage's operand copies feed nothing downstream.
    logic unused_final_operands;
    assign unused_final_operands = ^{a_q[STAGES-1], b_q[STAGES-1]};

    assign out_valid = vld_q[STAGES-1];
    assign sum       = s_q[STAGES-1];
    assign cout      = c_q[STAGES-1];
    assign ovf       = ovf_q;
endmodule

// File: tb/tb_pipelined_ripple_adder.sv
// Bench for pipelined_ripple_adder: directed vector table on a 4-bit/2-stage build,
// a 1-stage build, and streaming/stall/reset sequences on a 16-bit/4-stage build.
module tb_pipelined_ripple_adder;
    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst;

    logic       s_in_valid, s_in_ready, s_cin, s_sub, s_out_valid, s_out_ready, s_cout, s_ovf;
    logic [3:0] s_a0, s_a1, s_sum;
    logic        o_in_valid, o_in_ready, o_cin, o_sub, o_out_valid, o_out_ready, o_cout, o_ovf;
    logic [7:0]  o_a0, o_a1, o_sum;
    logic        b_in_valid, b_in_ready, b_cin, b_sub, b_out_valid, b_out_ready, b_cout, b_ovf;
    logic [15:0] b_a0, b_a1, b_sum;

    pipelined_ripple_adder #(.WIDTH(4), .STAGES(2)) u_small (
        .clk(clk), .rst(rst), .in_valid(s_in_valid), .in_ready(s_in_ready),
        .a0(s_a0), .a1(s_a1), .cin(s_cin), .sub(s_sub),
        .out_valid(s_out_valid), .out_ready(s_out_ready),
        .sum(s_sum), .cout(s_cout), .ovf(s_ovf));

    pipelined_ripple_adder #(.WIDTH(8), .STAGES(1)) u_one (
        .clk(clk), .rst(rst), .in_valid(o_in_valid), .in_ready(o_in_ready),
        .a0(o_a0), .a1(o_a1), .cin(o_cin), .sub(o_sub),
        .out_valid(o_out_valid), .out_ready(o_out_ready),
        .sum(o_sum), .cout(o_cout), .ovf(o_ovf));

    pipelined_ripple_adder #(.WIDTH(16), .STAGES(4)) u_big (
        .clk(clk), .rst(rst), .in_valid(b_in_valid), .in_ready(b_in_ready),
        .a0(b_a0), .a1(b_a1), .cin(b_cin), .sub(b_sub),
        .out_valid(b_out_valid), .out_ready(b_out_ready),
        .sum(b_sum), .cout(b_cout), .ovf(b_ovf));

    int checks = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [3:0] a0, a1;
        logic       cin, sub;
        logic [3:0] e_sum;
        logic       e_cout, e_ovf;
    } vec_t;

    typedef struct {
        logic [15:0] sum;
        logic        cout, ovf;
        int          acc_cyc;
    } exp_t;

    exp_t q[$];
    exp_t last_g;
    int   cyc = 0;
    int   n_out = 0;
    bit   chk_lat = 1'b0;

    function automatic exp_t model(input logic [15:0] a, input logic [15:0] b,
                                   input logic c, input logic s);
        exp_t r;
        logic [15:0] bb;
        logic [16:0] full;
        bb     = s ? ~b : b;
        full   = {1'b0, a} + {1'b0, bb} + {16'b0, s ? 1'b1 : c};
        r.sum  = full[15:0];
        r.cout = full[16];
        r.ovf  = (a[15] == bb[15]) && (full[15] != a[15]);
        r.acc_cyc = 0;
        return r;
    endfunction

    // One cycle on the 16-bit DUT: inputs already driven; settle, sample, clock, score.
    task automatic step();
        logic acc, tk;
        exp_t e, g, e2;
        #2;
        acc = b_in_valid && b_in_ready;
        tk  = b_out_valid && b_out_ready;
        g.sum = b_sum; g.cout = b_cout; g.ovf = b_ovf; g.acc_cyc = 0;
        e = model(b_a0, b_a1, b_cin, b_sub);
        e.acc_cyc = cyc;
        @(posedge clk);
        cyc++;
        #1;
        if (tk) begin
            n_out++;
            last_g = g;
            if (q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL big_unexpected_result actual=0x%0h expected=none", g.sum);
            end else begin
                e2 = q.pop_front();
                check("big_sum",  32'(g.sum),  32'(e2.sum));
                check("big_cout", 32'(g.cout), 32'(e2.cout));
                check("big_ovf",  32'(g.ovf),  32'(e2.ovf));
                if (chk_lat) check("big_latency", cyc - 1 - e2.acc_cyc, 4);
            end
        end
        if (acc) q.push_back(e);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout");
        $fatal(1);
    end

    initial begin
        vec_t vecs[10];
        bit   held;
        logic [15:0] h_sum;
        logic        h_cout, h_ovf;

        //            a0     a1     cin   sub   sum    cout  ovf
        vecs[0] = '{4'h7, 4'h1, 1'b0, 1'b0, 4'h8, 1'b0, 1'b1};
        vecs[1] = '{4'hF, 4'h1, 1'b0, 1'b0, 4'h0, 1'b1, 1'b0};
        vecs[2] = '{4'hF, 4'hF, 1'b1, 1'b0, 4'hF, 1'b1, 1'b0};
        vecs[3] = '{4'h3, 4'h5, 1'b0, 1'b1, 4'hE, 1'b0, 1'b0};
        vecs[4] = '{4'h8, 4'h1, 1'b0, 1'b1, 4'h7, 1'b1, 1'b1};
        vecs[5] = '{4'h5, 4'h2, 1'b1, 1'b0, 4'h8, 1'b0, 1'b1};
        vecs[6] = '{4'h0, 4'h0, 1'b0, 1'b1, 4'h0, 1'b1, 1'b0};
        vecs[7] = '{4'h4, 4'h4, 1'b1, 1'b1, 4'h0, 1'b1, 1'b0};
        vecs[8] = '{4'h8, 4'h8, 1'b0, 1'b0, 4'h0, 1'b1, 1'b1};
        vecs[9] = '{4'h6, 4'h6, 1'b1, 1'b0, 4'hD, 1'b0, 1'b1};

        rst = 1'b1;
        s_in_valid = 0; s_a0 = 0; s_a1 = 0; s_cin = 0; s_sub = 0; s_out_ready = 1;
        o_in_valid = 0; o_a0 = 0; o_a1 = 0; o_cin = 0; o_sub = 0; o_out_ready = 1;
        b_in_valid = 0; b_a0 = 0; b_a1 = 0; b_cin = 0; b_sub = 0; b_out_ready = 1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_small_in_ready", 32'(s_in_ready), 0);
        check("rst_big_in_ready",   32'(b_in_ready), 0);
        check("rst_big_out_valid",  32'(b_out_valid), 0);
        check("rst_big_sum",        32'(b_sum), 0);
        check("rst_big_cout",       32'(b_cout), 0);
        check("rst_small_out_valid", 32'(s_out_valid), 0);
        rst = 1'b0;
        #1;
        check("post_rst_big_in_ready", 32'(b_in_ready), 1);

        for (int i = 0; i < 10; i++) begin
            s_a0 = vecs[i].a0; s_a1 = vecs[i].a1; s_cin = vecs[i].cin; s_sub = vecs[i].sub;
            s_in_valid = 1'b1;
            @(posedge clk); #1;
            s_in_valid = 1'b0;
            check($sformatf("v%0d_not_yet", i), 32'(s_out_valid), 0);
            @(posedge clk); #1;
            check($sformatf("v%0d_valid", i), 32'(s_out_valid), 1);
            check($sformatf("v%0d_sum", i),   32'(s_sum),  32'(vecs[i].e_sum));
            check($sformatf("v%0d_cout", i),  32'(s_cout), 32'(vecs[i].e_cout));
            check($sformatf("v%0d_ovf", i),   32'(s_ovf),  32'(vecs[i].e_ovf));
        end

        o_a0 = 8'hFF; o_a1 = 8'h01; o_in_valid = 1'b1;
        @(posedge clk); #1;
        o_in_valid = 1'b0;
        check("one_stage_valid", 32'(o_out_valid), 1);
        check("one_stage_sum",   32'(o_sum), 0);
        check("one_stage_cout",  32'(o_cout), 1);
        check("one_stage_ovf",   32'(o_ovf), 0);

        // Back-to-back stream with no backpressure.
        chk_lat = 1'b1;
        n_out = 0;
        for (int i = 0; i < 100; i++) begin
            b_in_valid = 1'b1;
            if (i == 0) begin
                b_a0 = 16'hFFFF; b_a1 = 16'h0001; b_cin = 1'b0; b_sub = 1'b0;
            end else begin
                b_a0  = 16'($urandom_range(0, 65535));
                b_a1  = 16'($urandom_range(0, 65535));
                b_cin = 1'($urandom_range(0, 1));
                b_sub = 1'($urandom_range(0, 1));
            end
            #1;
            check("t4_in_ready", 32'(b_in_ready), 1);
            step();
            if (i == 4) begin
                check("t4_ffff_plus_1_sum",  32'(last_g.sum), 0);
                check("t4_ffff_plus_1_cout", 32'(last_g.cout), 1);
            end
        end
        b_in_valid = 1'b0;
        for (int t = 0; t < 20 && q.size() > 0; t++) step();
        check("t4_drained", q.size(), 0);
        check("t4_out_count", n_out, 100);

        // Stall: fill the pipe with the consumer blocked.
        chk_lat = 1'b0;
        n_out = 0;
        held = 1'b0;
        h_sum = 0; h_cout = 0; h_ovf = 0;
        b_out_ready = 1'b0;
        for (int i = 0; i < 8; i++) begin
            b_in_valid = 1'b1;
            b_a0  = 16'($urandom_range(0, 65535));
            b_a1  = 16'($urandom_range(0, 65535));
            b_cin = 1'($urandom_range(0, 1));
            b_sub = 1'($urandom_range(0, 1));
            step();
            if (i >= 3) check("t5_in_ready_low", 32'(b_in_ready), 0);
            if (held) begin
                check("t5_hold_valid", 32'(b_out_valid), 1);
                check("t5_hold_sum",   32'(b_sum),  32'(h_sum));
                check("t5_hold_cout",  32'(b_cout), 32'(h_cout));
                check("t5_hold_ovf",   32'(b_ovf),  32'(h_ovf));
            end else if (b_out_valid) begin
                held = 1'b1;
                h_sum = b_sum; h_cout = b_cout; h_ovf = b_ovf;
            end
        end
        check("t5_accepted", q.size(), 4);
        b_in_valid = 1'b0;
        b_out_ready = 1'b1;
        for (int t = 0; t < 20 && q.size() > 0; t++) step();
        check("t5_drained", q.size(), 0);
        check("t5_out_count", n_out, 4);
        check("t5_idle_valid", 32'(b_out_valid), 0);

        // Reset with three operations in flight.
        for (int i = 0; i < 3; i++) begin
            b_in_valid = 1'b1;
            b_a0 = 16'h1234 + 16'(i); b_a1 = 16'h4321; b_cin = 1'b1; b_sub = 1'b0;
            step();
        end
        b_in_valid = 1'b0;
        rst = 1'b1;
        #1;
        check("t6_in_ready_in_rst", 32'(b_in_ready), 0);
        step();
        q.delete();
        check("t6_out_valid", 32'(b_out_valid), 0);
        check("t6_sum",       32'(b_sum), 0);
        check("t6_cout",      32'(b_cout), 0);
        check("t6_ovf",       32'(b_ovf), 0);
        rst = 1'b0;
        #1;
        check("t6_in_ready_after", 32'(b_in_ready), 1);
        repeat (8) step();
        check("t6_no_stale", 32'(b_out_valid), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
